// File: rtl/rd_writeback_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_writeback_register_file_pkg
// Description : Shared constants and types for the rd writeback register
//               file: default widths, index/word types and the clear FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_writeback_register_file_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 32;
    localparam int ADDRESS_WIDTH_DEFAULT = 5;

    typedef logic [ADDRESS_WIDTH_DEFAULT-1:0] reg_index_t;
    typedef logic [DATA_WIDTH_DEFAULT-1:0]    word_t;

    // Zeroing sweep, then normal operation until the next reset.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_t;

endpackage : rd_writeback_register_file_pkg
`default_nettype wire

// File: rtl/rd_writeback_register_file_regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One registered register-file read port. Forwards a write
//               landing on the same edge (write-first), masks x0 to zero and
//               outputs zero while the file is not yet ready.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import rd_writeback_register_file_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic [ADDRESS_WIDTH-1:0] read_address_i,
    input  logic                     write_enable_i,
    input  logic [ADDRESS_WIDTH-1:0] write_address_i,
    input  logic [DATA_WIDTH-1:0]    write_data_i,
    input  logic [DATA_WIDTH-1:0]    array_data_i,
    output logic [DATA_WIDTH-1:0]    read_data_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // Select read value: zero when disabled or x0, forwarded write data on a
    // same-edge address match, otherwise the stored entry.
    always_comb begin
        data_d = '0;
        if (enable_i && (read_address_i != '0)) begin
            if (write_enable_i && (write_address_i == read_address_i)) begin
                data_d = write_data_i;
            end else begin
                data_d = array_data_i;
            end
        end
    end

    // Output register, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign read_data_o = data_q;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/rd_writeback_register_file.sv
`default_nettype none
// ============================================================================
// Module      : rd_writeback_register_file
// Description : Integer register file at the end of the rd writeback path.
//               One write port (rd), two registered read ports (rs1, rs2)
//               and a debug read port. A clear FSM zeroes entries 1..N-1
//               after reset so the array needs no bulk reset; x0 is always 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_writeback_register_file
    import rd_writeback_register_file_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEFAULT,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rd_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic [ADDRESS_WIDTH-1:0] rs1_address,
    input  logic [ADDRESS_WIDTH-1:0] rs2_address,
    output logic [DATA_WIDTH-1:0]    rs1_data,
    output logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [ADDRESS_WIDTH-1:0] debug_address,
    output logic [DATA_WIDTH-1:0]    debug_data,
    output logic                     ready,
    output logic                     write_ignored
);

    localparam int                     NUM_ENTRIES = 2 ** ADDRESS_WIDTH;
    localparam int                     NUM_PORTS   = 3;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX  = '1;
    localparam logic [ADDRESS_WIDTH-1:0] FIRST_INDEX = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam regfile_state_t         RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    // Storage: no reset, zeroed by the sweep instead.
    logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES];

    regfile_state_t             state_q;
    regfile_state_t             state_d;
    logic [ADDRESS_WIDTH-1:0]   clear_index_q;
    logic [ADDRESS_WIDTH-1:0]   clear_index_d;
    logic                       write_ignored_q;
    logic                       write_ignored_d;

    logic                       user_write;
    logic                       mem_we;
    logic [ADDRESS_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       ports_enabled;

    logic [ADDRESS_WIDTH-1:0]   port_address [NUM_PORTS];
    logic [DATA_WIDTH-1:0]      port_data    [NUM_PORTS];

    // State register: sweep position, FSM state and the drop-notification pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RESET_STATE;
            clear_index_q   <= FIRST_INDEX;
            write_ignored_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_index_q   <= clear_index_d;
            write_ignored_q <= write_ignored_d;
        end
    end

    // Next state: advance the sweep and leave CLEAR after the last entry.
    always_comb begin
        state_d         = state_q;
        clear_index_d   = clear_index_q;
        write_ignored_d = 1'b0;
        if (state_q == CLEAR) begin
            clear_index_d   = clear_index_q + 1'b1;
            write_ignored_d = rd_write_enable;
            if (clear_index_q == LAST_INDEX) begin
                state_d = READY;
            end
        end
    end

    // Outputs: share the single array write port between the sweep and rd.
    always_comb begin
        ports_enabled = (state_q == READY);
        user_write    = ports_enabled && rd_write_enable && (rd_address != '0);
        mem_we        = 1'b0;
        mem_waddr     = rd_address;
        mem_wdata     = rd_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_index_q;
            mem_wdata = '0;
        end else if (user_write) begin
            mem_we    = 1'b1;
        end
    end

    // Array write port.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign port_address[0] = rs1_address;
    assign port_address[1] = rs2_address;
    assign port_address[2] = debug_address;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_read_port
            regfile_read_port #(
                .DATA_WIDTH    (DATA_WIDTH),
                .ADDRESS_WIDTH (ADDRESS_WIDTH)
            ) u_port (
                .clock           (clock),
                .reset           (reset),
                .enable_i        (ports_enabled),
                .read_address_i  (port_address[p]),
                .write_enable_i  (user_write),
                .write_address_i (rd_address),
                .write_data_i    (rd_data),
                .array_data_i    (mem_q[port_address[p]]),
                .read_data_o     (port_data[p])
            );
        end
    endgenerate

    assign rs1_data      = port_data[0];
    assign rs2_data      = port_data[1];
    assign debug_data    = port_data[2];
    assign ready         = (state_q == READY);
    assign write_ignored = write_ignored_q;

endmodule : rd_writeback_register_file
`default_nettype wire

// File: doc/rd_writeback_register_file.md
Name: rd_writeback_register_file

Overview:
- Consumer end of the writeback (rd) path: accepts the single selected rd value each cycle and commits it to the 32-entry integer register file.
- Serves two synchronous read ports (rs1, rs2) to decode/execute, plus a debug read port.
- Sweeps all registers to zero after reset via a small clear FSM, so the array maps onto block RAM with no bulk reset.
- x0 is hardwired to zero.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH entries)
CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = go straight to READY with array contents undefined (x0 still reads 0)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rd_write_enable  input  1  commit rd_data to rd_address this cycle
rd_address  input  ADDRESS_WIDTH  destination register index
rd_data  input  DATA_WIDTH  writeback value (output of the rd selector)
rs1_address  input  ADDRESS_WIDTH  read port 1 index
rs2_address  input  ADDRESS_WIDTH  read port 2 index
rs1_data  output  DATA_WIDTH  registered read data, port 1
rs2_data  output  DATA_WIDTH  registered read data, port 2
debug_address  input  ADDRESS_WIDTH  debug read index
debug_data  output  DATA_WIDTH  registered read data, debug port
ready  output  1  high once the clear sweep is done; writes are accepted only when high
write_ignored  output  1  one-cycle pulse: a write request was dropped (see below)

Behaviour:
- Reset (reset=1 at an edge):
  - state <= CLEAR (CLEAR_ON_RESET=1) or READY (=0); clear_index <= 1.
  - rs1_data, rs2_data, debug_data <= 0; ready <= 0 (CLEAR_ON_RESET=0: ready <= 1); write_ignored <= 0.
  - Reset mid-sweep or mid-operation restarts the sweep from index 1.
- CLEAR state:
  - Each cycle writes 0 to entry clear_index, then clear_index++.
  - After writing index 2**ADDRESS_WIDTH-1 (31): state <= READY, ready <= 1.
  - Sweep is 31 cycles; ready rises on the 31st edge after reset deassertion.
  - All read outputs register 0 during CLEAR.
  - rd_write_enable=1 during CLEAR: write dropped, write_ignored pulses 1 on the next cycle.
- READY state:
  - Write: on an edge with rd_write_enable=1 and rd_address!=0, array[rd_address] <= rd_data.
  - Writes to x0 are discarded silently (no write_ignored pulse); x0 always reads 0.
  - Read latency is 1 cycle: rsN_data at edge k+1 reflects rsN_address sampled at edge k.
  - Write-first bypass: if the same edge writes address A and a read port samples A (A!=0), that port registers the new rd_data, not the stale array value. Applies independently to rs1, rs2 and debug.
  - Both read ports may address the same register; both return identical data.
  - No ordering between ports; one write per cycle is the only write path.
- Width rules:
  - Addresses are used unsigned and full width; no wrap concerns, since every index is valid.
  - Data is stored unmodified.
- FSM: CLEAR -> READY (sweep complete); any state -> CLEAR/READY per CLEAR_ON_RESET on reset; READY is otherwise terminal.

Decomposition:
- Shared core package:
  - DATA_WIDTH/ADDRESS_WIDTH defaults as constants.
  - typedef reg_index_t (logic [4:0]).
  - typedef word_t (logic [31:0]).
  - enum regfile_state_t {CLEAR, READY}.
- One natural sub-module, regfile_read_port: registered read with write-first bypass and x0 masking. Instantiated three times (rs1, rs2, debug).
- Top level holds the array, write logic and clear FSM.

Test Plan:
- Reset, CLEAR_ON_RESET=1 -> ready=0 for 30 cycles, ready=1 on the 31st edge; reading x1..x31 afterwards returns 0x00000000.
- During sweep, rd_write_enable=1, rd_address=5, rd_data=0xDEADBEEF -> write_ignored=1 next cycle; after ready, x5 reads 0x00000000.
- Ready: write x7=0x12345678 on edge k while rs1_address=7 -> rs1_data=0x12345678 at edge k+1 (bypass); rs2_address=7 one cycle later also returns 0x12345678.
- Write x0=0xFFFFFFFF -> rs1_address=0 reads 0x00000000, write_ignored stays 0.
- Write x31=0xA5A5A5A5, x1=0x00000001 back-to-back; rs1=31, rs2=1, debug=31 -> 0xA5A5A5A5, 0x00000001, 0xA5A5A5A5.
- Assert reset at sweep index 15, hold 1 cycle -> ready stays 0, sweep restarts; ready rises 31 cycles after reset deasserts.
